prime_scan: RTL
===============

# prime_scan

Sequencer for the 4-bit prime detector `prime_rec`, which drives DP=1 for 3, 5, 7, 11 and 13. On a start request it sweeps an inclusive range [lo, hi] through the detector, one value per cycle. Each detected prime goes out on a valid/ready stream, and the block reports the prime count at the end. It sits between the switch/button front end and the display/stream consumer in the lab top level.

## Interface
Parameters:
- CNT_W, default 5: width of prime_count. Must be ≥3; values that do not fit saturate.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clk.
- start  in  1  begin a sweep; sampled only in IDLE.
- lo  in  4  range low bound; latched on an accepted start.
- hi  in  4  range high bound; latched on an accepted start.
- out_ready  in  1  consumer can accept out_data.
- out_valid  out  1  out_data holds a prime awaiting acceptance.
- out_data  out  4  current prime.
- busy  out  1  high in SCAN and EMIT.
- done  out  1  one-cycle pulse when a sweep ends.
- err  out  1  high when the last sweep was rejected (lo>hi); held until the next accepted start.
- prime_count  out  CNT_W  primes accepted in the last or current sweep; held until the next accepted start.

## Operation
- FSM states: IDLE, SCAN, EMIT, DONE. All outputs are registered.
- Internal registers: cur[3:0], hi_q[3:0].
- IDLE, start=1:
  - Latch hi_q=hi, cur=lo, clear prime_count and err.
  - If lo>hi: set err=1 and go to DONE.
  - Otherwise go to SCAN.
- SCAN: the detector evaluates cur combinationally.
  - DP=1: load out_data=cur, set out_valid=1, go to EMIT.
  - DP=0, cur==hi_q: go to DONE.
  - DP=0, cur!=hi_q: cur=cur+1, stay in SCAN.
- EMIT: hold out_valid and out_data stable until out_valid && out_ready.
  - On that handshake: clear out_valid, prime_count=prime_count+1 (saturating at 2^CNT_W-1).
  - Then go to DONE if cur==hi_q; otherwise cur=cur+1 and go to SCAN.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Wrap-around: the end test is cur==hi_q, made before any increment, so hi=15 terminates without cur wrapping to 0.
- lo==hi: exactly one value is tested.
- start while busy or in DONE is ignored. It is not queued.
- lo/hi changes after latching have no effect on the running sweep.
- reset at any point:
  - FSM returns to IDLE.
  - out_valid=0, out_data=0, busy=0, done=0, err=0, prime_count=0, cur=0, hi_q=0.
  - Any pending out_data is dropped.

## Timing
- Start accepted at edge E0; SCAN of lo is active in cycle E0+1.
- Each non-prime value costs 1 cycle.
- Each prime costs 1 SCAN cycle plus k≥1 EMIT cycles.
- out_valid rises on the edge that leaves SCAN and falls on the edge that completes the handshake.
- Full sweep 0..15 with out_ready=1: 16 SCAN + 5 EMIT = 21 busy cycles, then 1 DONE cycle. done is high in the cycle after the last busy cycle.
- Rejected range (lo>hi): DONE in cycle E0+1, with err=1 and prime_count=0.
- Minimum back-to-back sweep spacing: start is accepted in the IDLE cycle that follows DONE.

## Configuration
- PRIME_SCAN_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in SCAN or EMIT forces DONE on the next edge, with out_valid=0 and err=1.
  - prime_count keeps the primes accepted so far.
  - abort takes priority over a simultaneous handshake: that handshake is not counted.
- PRIME_SCAN_ABORT_EN undefined: no abort port; every sweep runs to completion.

## Test plan
- Full range: reset, lo=0, hi=15, start pulse, out_ready=1 → out_data sequence 3,5,7,11,13; prime_count=5; done pulses 22 cycles after the start edge; err=0.
- Backpressure: lo=4, hi=8, out_ready low for 3 cycles whenever out_valid rises → out_data 5 held stable 4 cycles, then 7 held stable 4 cycles; prime_count=2; no value lost or duplicated.
- Boundaries:
  - lo=hi=13 → single output 13, count=1.
  - lo=hi=15 → no output, count=0, done after 2 cycles, no wrap.
- Rejected range: lo=9, hi=2 → done one cycle after start, err=1, prime_count=0, out_valid never high.
- Reset mid-sweep: lo=0, hi=15, assert reset while in EMIT holding 7 → next cycle all outputs 0 and FSM in IDLE; a new start (lo=10, hi=12) yields only 11.
- start during busy is ignored, and abort works when PRIME_SCAN_ABORT_EN is defined: abort in EMIT holding 5 (lo=0, hi=15, out_ready=0) → out_valid=0, err=1, prime_count=1.

Source files
------------

// File: rtl/prime_scan.sv
// Range sweeper around the 4-bit prime detector: streams each prime in [lo, hi] and counts them.
// Optional abort input is enabled by defining PRIME_SCAN_ABORT_EN.

module prime_rec (
    input  logic [3:0] value,
    output logic       dp
);
    // Lab detector: 2 is deliberately not flagged.
    always_comb begin
        dp = 1'b0;
        case (value)
            4'd3, 4'd5, 4'd7, 4'd11, 4'd13: dp = 1'b1;
            default:                        dp = 1'b0;
        endcase
    end
endmodule

module prime_scan #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       lo,
    input  logic [3:0]       hi,
    input  logic             out_ready,
`ifdef PRIME_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] prime_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0] state;
    logic [3:0] cur;
    logic [3:0] hi_q;
    logic       dp;
    logic       abort_req;

    prime_rec u_rec (
        .value (cur),
        .dp    (dp)
    );

`ifdef PRIME_SCAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= 4'd0;
            hi_q        <= 4'd0;
            out_valid   <= 1'b0;
            out_data    <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            prime_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hi_q        <= hi;
                        cur         <= lo;
                        prime_count <= '0;
                        if (lo > hi) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (abort_req) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (dp) begin
                        out_data  <= cur;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (cur == hi_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cur <= cur + 4'd1;
                    end
                end
                EMIT: begin
                    // Abort beats a same-cycle handshake; that prime is not counted.
                    if (abort_req) begin
                        out_valid <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (prime_count != '1)
                            prime_count <= prime_count + CNT_W'(1);
                        // End test precedes the increment so hi=15 never wraps cur.
                        if (cur == hi_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur   <= cur + 4'd1;
                            state <= SCAN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
